// File: rtl/change_dispenser_if.sv
// Request, restock and coin-bus signals between a vending controller and the change dispenser.
// The master drives requests and hopper acks; the slave reports coins, status and tube stock.
interface change_dispenser_if;
    logic        start;
    logic [15:0] amount;
    logic        coin_ack;
    logic        load_en;
    logic [1:0]  load_code;
    logic [7:0]  load_count;
    logic [1:0]  coin;
    logic        busy;
    logic        done;
    logic        short;
    logic [15:0] remainder;
    logic [7:0]  left_1;
    logic [7:0]  left_2;
    logic [7:0]  left_5;

    modport master (
        output start, amount, coin_ack, load_en, load_code, load_count,
        input  coin, busy, done, short, remainder, left_1, left_2, left_5
    );

    modport slave (
        input  start, amount, coin_ack, load_en, load_code, load_count,
        output coin, busy, done, short, remainder, left_1, left_2, left_5
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays an amount from 5/2/1-unit coin tubes, one acked coin at a time,
// with a one-cycle gap between coins and a short pulse when the stock cannot cover the amount.
module change_dispenser (
    input logic               clk,
    input logic               RESET,
    change_dispenser_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PICK, DISP, GAP, DONE, SHORT} state_t;

    state_t      state_q, state_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] remainder_q, remainder_d;
    logic [1:0]  coin_q, coin_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        short_q, short_d;
    logic [7:0]  left_1_q, left_1_d;
    logic [7:0]  left_2_q, left_2_d;
    logic [7:0]  left_5_q, left_5_d;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    function automatic logic [15:0] coin_value(input logic [1:0] code);
        case (code)
            2'd1:    return 16'd1;
            2'd2:    return 16'd2;
            2'd3:    return 16'd5;
            default: return 16'd0;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        remainder_d = remainder_q;
        coin_d      = coin_q;
        done_d      = 1'b0;
        short_d     = 1'b0;
        left_1_d    = left_1_q;
        left_2_d    = left_2_q;
        left_5_d    = left_5_q;

        case (state_q)
            IDLE: begin
                // Restock lands in the same edge as an accepted start, so PICK sees it.
                if (bus.load_en) begin
                    case (bus.load_code)
                        2'd1:    left_1_d = sat_add8(left_1_q, bus.load_count);
                        2'd2:    left_2_d = sat_add8(left_2_q, bus.load_count);
                        2'd3:    left_5_d = sat_add8(left_5_q, bus.load_count);
                        default: ;
                    endcase
                end
                if (bus.start) begin
                    rem_d       = bus.amount;
                    remainder_d = 16'd0;
                    state_d     = PICK;
                end
            end
            PICK: begin
                if (rem_q == 16'd0) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (rem_q >= 16'd5 && left_5_q != 8'd0) begin
                    coin_d  = 2'd3;
                    state_d = DISP;
                end else if (rem_q >= 16'd2 && left_2_q != 8'd0) begin
                    coin_d  = 2'd2;
                    state_d = DISP;
                end else if (left_1_q != 8'd0) begin
                    coin_d  = 2'd1;
                    state_d = DISP;
                end else begin
                    short_d     = 1'b1;
                    remainder_d = rem_q;
                    state_d     = SHORT;
                end
            end
            DISP: begin
                if (bus.coin_ack) begin
                    rem_d = rem_q - coin_value(coin_q);
                    case (coin_q)
                        2'd1:    if (left_1_q != 8'd0) left_1_d = left_1_q - 8'd1;
                        2'd2:    if (left_2_q != 8'd0) left_2_d = left_2_q - 8'd1;
                        2'd3:    if (left_5_q != 8'd0) left_5_d = left_5_q - 8'd1;
                        default: ;
                    endcase
                    coin_d  = 2'd0;
                    state_d = GAP;
                end
            end
            GAP:     state_d = PICK;
            DONE:    state_d = IDLE;
            SHORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q     <= IDLE;
            rem_q       <= 16'd0;
            remainder_q <= 16'd0;
            coin_q      <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            left_1_q    <= 8'd0;
            left_2_q    <= 8'd0;
            left_5_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            remainder_q <= remainder_d;
            coin_q      <= coin_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            short_q     <= short_d;
            left_1_q    <= left_1_d;
            left_2_q    <= left_2_d;
            left_5_q    <= left_5_d;
        end
    end

    assign bus.coin      = coin_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.short     = short_q;
    assign bus.remainder = remainder_q;
    assign bus.left_1    = left_1_q;
    assign bus.left_2    = left_2_q;
    assign bus.left_5    = left_5_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: restock, greedy payout, short, saturation, busy lockout, reset abort.
module tb_change_dispenser;
    logic clk;
    logic RESET;
    int   checks;
    int   errors;

    change_dispenser_if bus();

    change_dispenser dut (
        .clk  (clk),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] code, input logic [7:0] count);
        bus.load_en    = 1'b1;
        bus.load_code  = code;
        bus.load_count = count;
        tick();
        bus.load_en    = 1'b0;
    endtask

    task automatic start_pay(input logic [15:0] amt);
        bus.start  = 1'b1;
        bus.amount = amt;
        tick();
        bus.start  = 1'b0;
    endtask

    // Entered in PICK; leaves the DUT back in PICK after the gap cycle.
    task automatic pay_coin(input string tag, input logic [1:0] code);
        tick();
        check({tag, "_coin"}, bus.coin, code);
        tick();
        check({tag, "_hold"}, bus.coin, code);
        bus.coin_ack = 1'b1;
        tick();
        bus.coin_ack = 1'b0;
        check({tag, "_gap"}, bus.coin, 0);
        tick();
    endtask

    task automatic expect_done(input string tag);
        tick();
        check({tag, "_done"}, bus.done, 1);
        check({tag, "_noshort"}, bus.short, 0);
        check({tag, "_coin0"}, bus.coin, 0);
        tick();
        check({tag, "_done_clr"}, bus.done, 0);
        check({tag, "_idle"}, bus.busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_coin"}, bus.coin, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_short"}, bus.short, 0);
        check({tag, "_rem"}, bus.remainder, 0);
        check({tag, "_l1"}, bus.left_1, 0);
        check({tag, "_l2"}, bus.left_2, 0);
        check({tag, "_l5"}, bus.left_5, 0);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        clk            = 1'b0;
        RESET          = 1'b1;
        bus.start      = 1'b0;
        bus.amount     = 16'd0;
        bus.coin_ack   = 1'b0;
        bus.load_en    = 1'b0;
        bus.load_code  = 2'd0;
        bus.load_count = 8'd0;
        repeat (2) tick();
        check_reset_outputs("rst");
        RESET = 1'b0;

        // Greedy payout of 13 from 5x2, 2x3, 1x5
        load(2'd3, 8'd2);
        load(2'd2, 8'd3);
        load(2'd1, 8'd5);
        load(2'd0, 8'd7);
        check("load_l5", bus.left_5, 2);
        check("load_l2", bus.left_2, 3);
        check("load_l1", bus.left_1, 5);
        start_pay(16'd13);
        check("p13_busy", bus.busy, 1);
        check("p13_pick_coin", bus.coin, 0);
        pay_coin("p13_a", 2'd3);
        pay_coin("p13_b", 2'd3);
        pay_coin("p13_c", 2'd2);
        pay_coin("p13_d", 2'd1);
        expect_done("p13");
        check("p13_l5", bus.left_5, 0);
        check("p13_l2", bus.left_2, 2);
        check("p13_l1", bus.left_1, 4);
        check("p13_remainder", bus.remainder, 0);

        // Zero amount: done two cycles after start, never a coin
        start_pay(16'd0);
        check("z_busy1", bus.busy, 1);
        check("z_done_early", bus.done, 0);
        check("z_coin1", bus.coin, 0);
        tick();
        check("z_done", bus.done, 1);
        check("z_busy2", bus.busy, 1);
        check("z_coin2", bus.coin, 0);
        tick();
        check("z_done_clr", bus.done, 0);
        check("z_busy3", bus.busy, 0);

        // Short: only one 5-unit coin for an amount of 7
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        load(2'd3, 8'd1);
        start_pay(16'd7);
        pay_coin("s7", 2'd3);
        tick();
        check("s7_short", bus.short, 1);
        check("s7_nodone", bus.done, 0);
        check("s7_remainder", bus.remainder, 2);
        tick();
        check("s7_short_clr", bus.short, 0);
        check("s7_idle", bus.busy, 0);
        check("s7_rem_hold", bus.remainder, 2);
        check("s7_l5", bus.left_5, 0);

        // Pay 6 with no fives: one 2 then four 1s
        load(2'd2, 8'd1);
        load(2'd1, 8'd10);
        start_pay(16'd6);
        check("p6_rem_clr", bus.remainder, 0);
        pay_coin("p6_a", 2'd2);
        pay_coin("p6_b", 2'd1);
        pay_coin("p6_c", 2'd1);
        pay_coin("p6_d", 2'd1);
        pay_coin("p6_e", 2'd1);
        expect_done("p6");
        check("p6_l2", bus.left_2, 0);
        check("p6_l1", bus.left_1, 6);

        // Saturating restock, then loads and starts ignored while busy
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        load(2'd1, 8'd200);
        check("sat_200", bus.left_1, 200);
        load(2'd1, 8'd100);
        check("sat_255", bus.left_1, 255);
        start_pay(16'd3);
        tick();
        check("bz_coin", bus.coin, 1);
        bus.load_en    = 1'b1;
        bus.load_code  = 2'd1;
        bus.load_count = 8'd5;
        bus.start      = 1'b1;
        bus.amount     = 16'd9;
        tick();
        bus.load_en = 1'b0;
        bus.start   = 1'b0;
        check("bz_load_ignored", bus.left_1, 255);
        check("bz_coin_hold", bus.coin, 1);
        bus.coin_ack = 1'b1;
        tick();
        bus.coin_ack = 1'b0;
        check("bz_gap", bus.coin, 0);
        check("bz_dec", bus.left_1, 254);
        tick();
        pay_coin("bz_b", 2'd1);
        pay_coin("bz_c", 2'd1);
        expect_done("bz");
        check("bz_l1", bus.left_1, 252);

        // Stalled ack, then reset aborts the payout with priority over every input
        start_pay(16'd1);
        tick();
        check("st_coin", bus.coin, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("st_hold", bus.coin, 1);
            check("st_stock", bus.left_1, 252);
            check("st_busy", bus.busy, 1);
        end
        RESET          = 1'b1;
        bus.start      = 1'b1;
        bus.amount     = 16'd5;
        bus.coin_ack   = 1'b1;
        bus.load_en    = 1'b1;
        bus.load_code  = 2'd1;
        bus.load_count = 8'd9;
        tick();
        check_reset_outputs("abort");
        RESET        = 1'b0;
        bus.start    = 1'b0;
        bus.coin_ack = 1'b0;
        bus.load_en  = 1'b0;
        tick();
        check("abort_idle", bus.busy, 0);
        check("abort_coin", bus.coin, 0);
        check("abort_l1", bus.left_1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got %0d expected %0d", 1, 0);
        $fatal(1);
    end
endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have these ports, clock and reset first: clk input 1 (single clock, all logic on rising edge); RESET input 1 (synchronous, active-high).
REQ-002 SHALL have: start input 1, a one-cycle request to pay out `amount`.
REQ-003 SHALL have: amount input 16, the change value in units, sampled only on an accepted start.
REQ-004 SHALL have: coin_ack input 1, the hopper acknowledging that the presented coin was ejected.
REQ-005 SHALL have: load_en input 1, load_code input 2 and load_count input 8, which restock one coin tube.
REQ-006 SHALL have: coin output 2, using the coin-bus code (0 none, 1 = 1 unit, 2 = 2 units, 3 = 5 units).
REQ-007 SHALL have: busy output 1, done output 1 (one-cycle pulse) and short output 1 (one-cycle pulse).
REQ-008 SHALL have: remainder output 16, the unpaid units latched at short.
REQ-009 SHALL have: left_1, left_2 and left_5 outputs, each 8 bits, giving tube stock.

Function
REQ-010 States SHALL be IDLE, PICK, DISP, GAP, DONE and SHORT; busy = 1 in every state except IDLE.
REQ-011 In IDLE, when start = 1, the block SHALL latch amount into a 16-bit rem register and go to PICK on the next edge.
REQ-012 start SHALL be ignored in every state except IDLE.
REQ-013 Coin selection in PICK, applied in the order given, SHALL be:
- if rem = 0, go to DONE;
- else choose the largest denomination d in {5, 2, 1} with d <= rem and stock > 0, drive coin with its code, and go to DISP;
- if no such d exists, go to SHORT.
REQ-014 In DISP, coin SHALL hold its nonzero code until coin_ack = 1, with no timeout.
- On the ack edge: rem -= d, the matching left_x decrements by 1, and the state goes to GAP.
- coin_ack SHALL be ignored in all states except DISP.
REQ-015 GAP SHALL last exactly one cycle with coin = 0, then return to PICK, so consecutive coins are separated by at least one idle cycle.
REQ-016 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-017 SHORT SHALL assert short for one cycle with remainder = rem, then return to IDLE.
- remainder SHALL hold that value until the next accepted start, which clears it to 0.
REQ-018 Latency: a start accepted at edge N SHALL give PICK after edge N+1 and the first coin visible after edge N+2.
REQ-019 amount = 0 SHALL produce done after edge N+2 and no coin.
REQ-020 Restock (load_en = 1) SHALL be applied only in IDLE and ignored in all other states.
- It adds load_count to the tube selected by load_code: 1→left_1, 2→left_2, 3→left_5.
- load_code = 0 SHALL have no effect.
- The add SHALL saturate at 255.
REQ-021 When load_en and start are both 1 in IDLE, both SHALL be accepted; PICK then sees the restocked value.
REQ-022 Arithmetic on stock SHALL never wrap: a decrement occurs only when stock > 0, which is guaranteed by REQ-013.
REQ-023 done and short SHALL never be asserted in the same cycle.

Reset
REQ-024 While RESET = 1 on a clock edge, the block SHALL set: state IDLE, coin 0, busy 0, done 0, short 0, remainder 0, rem 0, and left_1/left_2/left_5 to 0.
REQ-025 RESET SHALL take priority over start, load_en and coin_ack.
REQ-026 RESET asserted mid-payout SHALL abort the payout; no stock is restored and coins already acked stay decremented.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Load left_5 = 2, left_2 = 3, left_1 = 5; start with amount = 13; ack each coin after 1 cycle → coin sequence 3, 3, 2, 1, each separated by a coin = 0 gap; done pulse; left_5 = 0, left_2 = 2, left_1 = 4; remainder = 0.
- start with amount = 0 → done exactly 2 cycles after start; coin stays 0; busy high for 2 cycles.
- Stock only left_5 = 1; start with amount = 7 → one coin 3; then short pulse with remainder = 2; done never asserted; left_5 = 0.
- Stock left_5 = 0, left_2 = 1, left_1 = 10; start with amount = 6 → coin sequence 2, 1, 1, 1, 1; left_2 = 0, left_1 = 6.
- Load left_1 with 200 then 100 → left_1 = 255; a load issued while busy leaves stock unchanged; a start while busy is ignored, so rem and coin are unaffected.
- Hold coin_ack low for 5 cycles in DISP → coin holds its code and no stock changes; then assert RESET → on the next edge every output is at its reset value and the state is IDLE.
